// File: rtl/instr_fetch.sv
// Purpose    : instruction fetch unit; holds the PC, reads 32-bit words from
//              instruction memory and hands them to the core with a valid flag.
// Latency    : first INSTR_VALID 2 edges after RESET falls with a zero-wait memory,
//              +1 cycle per busywait cycle; unstalled throughput 1 instr / 2 cycles.
// Backpressure: STALL holds the delivered word indefinitely; BRANCH_EN overrides STALL.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   STALL               core not ready to take the presented instruction
//   BRANCH_EN/_TARGET   redirect request and address (bits [1:0] ignored)
//   PC, INSTRUCTION     presented instruction and its address
//   INSTR_VALID         PC/INSTRUCTION valid for the core
//   MEM_READ/MEM_ADDR   instruction memory read request and 4-aligned byte address
//   MEM_READDATA        read data, valid when MEM_BUSYWAIT=0 with MEM_READ=1
//   MEM_BUSYWAIT        memory not ready
module instr_fetch #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STALL,
  input  logic                BRANCH_EN,
  input  logic [PC_WIDTH-1:0] BRANCH_TARGET,
  output logic [PC_WIDTH-1:0] PC,
  output logic [31:0]         INSTRUCTION,
  output logic                INSTR_VALID,
  output logic                MEM_READ,
  output logic [PC_WIDTH-1:0] MEM_ADDR,
  input  logic [31:0]         MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);

  typedef enum logic {FETCH = 1'b0, DELIVER = 1'b1} state_t;

  state_t              state_q, state_nxt;
  logic [PC_WIDTH-1:0] pc_q, pc_nxt;
  logic [31:0]         instr_q, instr_nxt;
  logic                valid_q, valid_nxt;
  logic                read_q, read_nxt;
  logic [PC_WIDTH-1:0] addr_q, addr_nxt;
  logic                redir_pend_q, redir_pend_nxt;
  logic [PC_WIDTH-1:0] redir_tgt_q, redir_tgt_nxt;

  logic [PC_WIDTH-1:0] tgt_aligned;
  logic [PC_WIDTH-1:0] pc_plus4;

  assign tgt_aligned = BRANCH_TARGET & ~PC_WIDTH'(3);
  assign pc_plus4    = pc_q + PC_WIDTH'(4);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      valid_q      <= 1'b0;
      read_q       <= 1'b0;
      addr_q       <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= RESET_PC;
    end else begin
      state_q      <= state_nxt;
      pc_q         <= pc_nxt;
      instr_q      <= instr_nxt;
      valid_q      <= valid_nxt;
      read_q       <= read_nxt;
      addr_q       <= addr_nxt;
      redir_pend_q <= redir_pend_nxt;
      redir_tgt_q  <= redir_tgt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    pc_nxt         = pc_q;
    instr_nxt      = instr_q;
    valid_nxt      = valid_q;
    read_nxt       = read_q;
    addr_nxt       = addr_q;
    redir_pend_nxt = redir_pend_q;
    redir_tgt_nxt  = redir_tgt_q;

    case (state_q)
      FETCH: begin
        if (!read_q) begin
          // Request not yet raised (only right after reset): nothing is in
          // flight, so a redirect can retarget the request directly.
          read_nxt = 1'b1;
          if (BRANCH_EN) begin
            pc_nxt   = tgt_aligned;
            addr_nxt = tgt_aligned;
          end else begin
            addr_nxt = pc_q;
          end
        end else if (!MEM_BUSYWAIT) begin
          if (BRANCH_EN) begin
            // Newest redirect wins over a saved one; returned word is stale.
            pc_nxt         = tgt_aligned;
            addr_nxt       = tgt_aligned;
            redir_pend_nxt = 1'b0;
          end else if (redir_pend_q) begin
            pc_nxt         = redir_tgt_q;
            addr_nxt       = redir_tgt_q;
            redir_pend_nxt = 1'b0;
          end else begin
            instr_nxt = MEM_READDATA;
            valid_nxt = 1'b1;
            read_nxt  = 1'b0;
            state_nxt = DELIVER;
          end
        end else if (BRANCH_EN) begin
          // The memory must finish the current read, so remember the target
          // and retarget once the data returns.
          redir_pend_nxt = 1'b1;
          redir_tgt_nxt  = tgt_aligned;
        end
      end

      DELIVER: begin
        if (BRANCH_EN) begin
          pc_nxt    = tgt_aligned;
          addr_nxt  = tgt_aligned;
          valid_nxt = 1'b0;
          read_nxt  = 1'b1;
          state_nxt = FETCH;
        end else if (!STALL) begin
          // Next request is raised on the accept edge to keep 2 cycles/instr.
          pc_nxt    = pc_plus4;
          addr_nxt  = pc_plus4;
          valid_nxt = 1'b0;
          read_nxt  = 1'b1;
          state_nxt = FETCH;
        end
      end

      default: state_nxt = FETCH;
    endcase
  end

  assign PC          = pc_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = valid_q;
  assign MEM_READ    = read_q;
  assign MEM_ADDR    = addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose    : bench for instr_fetch with a busywait instruction memory model.
// Latency    : n/a (testbench).
// Backpressure: STALL and BRANCH_EN driven per scenario.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RESET, STALL, BRANCH_EN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] PC, INSTRUCTION, MEM_ADDR, MEM_READDATA;
  logic        INSTR_VALID, MEM_READ, MEM_BUSYWAIT;

  int checks = 0;
  int passes = 0;

  // Memory model: each read holds busywait for cur_wait cycles, word = 0xB00 | addr.
  int wait_n    = 0;
  bit rand_wait = 1'b0;
  int cnt       = 0;
  int cur_wait  = 0;

  instr_fetch #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_EN(BRANCH_EN),
    .BRANCH_TARGET(BRANCH_TARGET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .INSTR_VALID(INSTR_VALID), .MEM_READ(MEM_READ), .MEM_ADDR(MEM_ADDR),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  assign MEM_BUSYWAIT = MEM_READ && (cnt < cur_wait);
  assign MEM_READDATA = 32'h0000_0B00 | MEM_ADDR;

  always @(posedge CLK) begin
    if (RESET || !MEM_READ || !MEM_BUSYWAIT) begin
      cnt      <= 0;
      cur_wait <= rand_wait ? int'($urandom_range(0, 3)) : wait_n;
    end else begin
      cnt <= cnt + 1;
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1; STALL = 1'b0; BRANCH_EN = 1'b0; BRANCH_TARGET = 32'h0;
    step(); step();
    RESET = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (INSTR_VALID) begin found = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    wait_n = 0;
    RESET = 1'b1; STALL = 1'b0; BRANCH_EN = 1'b1; BRANCH_TARGET = 32'h44;
    step(); step();
    BRANCH_EN = 1'b0;
    checks++; if (PC !== 32'h0) $display("FAIL rst_pc: got %h want %h", PC, 32'h0); else passes++;
    checks++; if (INSTRUCTION !== 32'h0) $display("FAIL rst_instr: got %h want 0", INSTRUCTION); else passes++;
    checks++; if (INSTR_VALID !== 1'b0) $display("FAIL rst_valid: got %b want 0", INSTR_VALID); else passes++;
    checks++; if (MEM_READ !== 1'b0) $display("FAIL rst_memread: got %b want 0", MEM_READ); else passes++;
    checks++; if (MEM_ADDR !== 32'h0) $display("FAIL rst_memaddr: got %h want 0", MEM_ADDR); else passes++;
    RESET = 1'b0;
    step();
    checks++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 32'h0 || INSTR_VALID !== 1'b0)
      $display("FAIL rst_first_req: read=%b addr=%h valid=%b want 1/0/0", MEM_READ, MEM_ADDR, INSTR_VALID);
    else passes++;
    step();
    checks++; if (INSTR_VALID !== 1'b1 || PC !== 32'h0 || INSTRUCTION !== 32'h0B00)
      $display("FAIL rst_latency: valid=%b pc=%h instr=%h want 1/0/00000b00", INSTR_VALID, PC, INSTRUCTION);
    else passes++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] ep;
    wait_n = 0;
    do_reset();
    step(); step();
    for (int k = 0; k < 8; k++) begin
      checks++; if (INSTR_VALID !== (k % 2 == 0))
        $display("FAIL zw_valid_%0d: got %b want %b", k, INSTR_VALID, (k % 2 == 0));
      else passes++;
      if (k % 2 == 0) begin
        ep = 32'(4 * (k / 2));
        checks++; if (PC !== ep || INSTRUCTION !== (32'h0B00 | ep))
          $display("FAIL zw_pc_%0d: pc=%h instr=%h want %h/%h", k, PC, INSTRUCTION, ep, 32'h0B00 | ep);
        else passes++;
      end
      step();
    end
  endtask

  task automatic test_busywait();
    bit prev_valid = 1'b0, exp_valid = 1'b0;
    int run = 0, last_rise = 0, nrise = 0;
    wait_n = 3;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      step();
      if (exp_valid) begin
        checks++; if (INSTR_VALID !== 1'b1) $display("FAIL bw_valid_after_bw: got %b want 1", INSTR_VALID);
        else passes++;
        exp_valid = 1'b0;
      end
      if (MEM_READ) run++;
      else if (run > 0) begin
        checks++; if (run != 4) $display("FAIL bw_read_len: got %0d want 4", run); else passes++;
        run = 0;
      end
      if (INSTR_VALID && !prev_valid) begin
        if (nrise > 0) begin
          checks++; if (c - last_rise != 5) $display("FAIL bw_spacing: got %0d want 5", c - last_rise);
          else passes++;
        end
        last_rise = c; nrise++;
      end
      if (MEM_READ && !MEM_BUSYWAIT) exp_valid = 1'b1;
      prev_valid = INSTR_VALID;
    end
    checks++; if (nrise < 5) $display("FAIL bw_count: got %0d valids want >=5", nrise); else passes++;
    wait_n = 0;
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    wait_n = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (INSTR_VALID && PC == 32'h8) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) $display("FAIL st_reach8: got no valid at pc 8 want one"); else passes++;
    STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (INSTR_VALID !== 1'b1 || PC !== 32'h8 || INSTRUCTION !== 32'h0B08 || MEM_READ !== 1'b0)
        $display("FAIL st_hold_%0d: valid=%b pc=%h instr=%h read=%b want 1/8/b08/0", i, INSTR_VALID, PC, INSTRUCTION, MEM_READ);
      else passes++;
    end
    STALL = 1'b0;
    step();
    checks++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 32'hC || INSTR_VALID !== 1'b0)
      $display("FAIL st_next_fetch: read=%b addr=%h valid=%b want 1/c/0", MEM_READ, MEM_ADDR, INSTR_VALID);
    else passes++;
    step();
    checks++; if (INSTR_VALID !== 1'b1 || PC !== 32'hC) $display("FAIL st_next_valid: valid=%b pc=%h want 1/c", INSTR_VALID, PC);
    else passes++;
  endtask

  task automatic test_branch_deliver();
    bit found;
    logic [31:0] tgts [2];
    tgts[0] = 32'h40; tgts[1] = 32'h43;
    wait_n = 0;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      wait_valid(10, found);
      checks++; if (!found) $display("FAIL bd_wait_%0d: got no valid want one", t); else passes++;
      STALL = 1'b1; BRANCH_EN = 1'b1; BRANCH_TARGET = tgts[t];
      step();
      BRANCH_EN = 1'b0; STALL = 1'b0;
      checks++; if (INSTR_VALID !== 1'b0 || MEM_READ !== 1'b1 || MEM_ADDR !== 32'h40)
        $display("FAIL bd_req_%0d: valid=%b read=%b addr=%h want 0/1/40", t, INSTR_VALID, MEM_READ, MEM_ADDR);
      else passes++;
      step();
      checks++; if (INSTR_VALID !== 1'b1 || PC !== 32'h40 || INSTRUCTION !== 32'h0B40)
        $display("FAIL bd_valid_%0d: valid=%b pc=%h instr=%h want 1/40/b40", t, INSTR_VALID, PC, INSTRUCTION);
      else passes++;
    end
  endtask

  task automatic test_branch_busy();
    bit found;
    wait_n = 0;
    do_reset();
    wait_valid(10, found);
    wait_n = 3;
    BRANCH_EN = 1'b1; BRANCH_TARGET = 32'h10;
    step();
    BRANCH_TARGET = 32'h80;
    step();
    BRANCH_TARGET = 32'h90;
    step();
    BRANCH_EN = 1'b0;
    checks++; if (MEM_READ !== 1'b1 || MEM_ADDR !== 32'h10 || PC !== 32'h10 || INSTR_VALID !== 1'b0)
      $display("FAIL bb_inflight: read=%b addr=%h pc=%h valid=%b want 1/10/10/0", MEM_READ, MEM_ADDR, PC, INSTR_VALID);
    else passes++;
    step();
    step();
    checks++; if (INSTR_VALID !== 1'b0 || MEM_READ !== 1'b1 || MEM_ADDR !== 32'h90 || PC !== 32'h90)
      $display("FAIL bb_redirect: valid=%b read=%b addr=%h pc=%h want 0/1/90/90", INSTR_VALID, MEM_READ, MEM_ADDR, PC);
    else passes++;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (INSTR_VALID !== (i == 4)) $display("FAIL bb_valid_t%0d: got %b want %b", i, INSTR_VALID, (i == 4));
      else passes++;
    end
    checks++; if (PC !== 32'h90 || INSTRUCTION !== 32'h0B90)
      $display("FAIL bb_refetch: pc=%h instr=%h want 90/b90", PC, INSTRUCTION);
    else passes++;
    wait_n = 0;
  endtask

  task automatic test_reset_mid_wrap();
    bit found;
    wait_n = 3;
    do_reset();
    step(); step();
    RESET = 1'b1;
    step();
    checks++; if (MEM_READ !== 1'b0 || INSTR_VALID !== 1'b0 || PC !== 32'h0 || MEM_ADDR !== 32'h0)
      $display("FAIL mr_state: read=%b valid=%b pc=%h addr=%h want 0/0/0/0", MEM_READ, INSTR_VALID, PC, MEM_ADDR);
    else passes++;
    RESET = 1'b0;
    wait_valid(20, found);
    checks++; if (!found || PC !== 32'h0 || INSTRUCTION !== 32'h0B00)
      $display("FAIL mr_refetch: found=%b pc=%h instr=%h want 1/0/b00", found, PC, INSTRUCTION);
    else passes++;
    wait_n = 0;
    do_reset();
    wait_valid(10, found);
    BRANCH_EN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    step();
    BRANCH_EN = 1'b0;
    step();
    checks++; if (INSTR_VALID !== 1'b1 || PC !== 32'hFFFF_FFFC || INSTRUCTION !== 32'hFFFF_FFFC)
      $display("FAIL wr_top: valid=%b pc=%h instr=%h want 1/fffffffc/fffffffc", INSTR_VALID, PC, INSTRUCTION);
    else passes++;
    step();
    checks++; if (PC !== 32'h0 || MEM_ADDR !== 32'h0 || MEM_READ !== 1'b1)
      $display("FAIL wr_wrap: pc=%h addr=%h read=%b want 0/0/1", PC, MEM_ADDR, MEM_READ);
    else passes++;
    step();
    checks++; if (INSTR_VALID !== 1'b1 || PC !== 32'h0 || INSTRUCTION !== 32'h0B00)
      $display("FAIL wr_valid: valid=%b pc=%h instr=%h want 1/0/b00", INSTR_VALID, PC, INSTRUCTION);
    else passes++;
  endtask

  // Reference: the next delivered PC is the last branch target (low bits
  // cleared) seen since the previous delivery, else previous PC + 4.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] p_pc = 32'h0, p_instr = 32'h0, p_addr = 32'h0;
    bit p_hold = 1'b0, p_busy = 1'b0;
    int idle = 0, delivered = 0, errs = 0;
    rand_wait = 1'b1;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      step();
      if (INSTR_VALID) begin
        checks++; if (PC !== exp_pc || INSTRUCTION !== (32'h0B00 | exp_pc)) begin
          if (errs < 5) $display("FAIL rnd_deliver c%0d: pc=%h instr=%h want %h/%h", c, PC, INSTRUCTION, exp_pc, 32'h0B00 | exp_pc);
          errs++;
        end else passes++;
        if (!p_hold) delivered++;
        idle = 0;
      end else idle++;
      if (p_hold) begin
        checks++; if (INSTR_VALID !== 1'b1 || PC !== p_pc || INSTRUCTION !== p_instr) begin
          if (errs < 5) $display("FAIL rnd_stall_hold c%0d: valid=%b pc=%h want 1/%h", c, INSTR_VALID, PC, p_pc);
          errs++;
        end else passes++;
      end
      if (p_busy) begin
        checks++; if (MEM_READ !== 1'b1 || MEM_ADDR !== p_addr) begin
          if (errs < 5) $display("FAIL rnd_req_held c%0d: read=%b addr=%h want 1/%h", c, MEM_READ, MEM_ADDR, p_addr);
          errs++;
        end else passes++;
      end
      if (MEM_ADDR[1:0] != 2'b00) begin
        checks++; errs++;
        $display("FAIL rnd_align c%0d: addr=%h want low bits 00", c, MEM_ADDR);
      end
      if (idle > 30) begin
        checks++;
        $display("FAIL rnd_timeout c%0d: got %0d idle cycles want <=30", c, idle);
        break;
      end
      STALL         = ($urandom_range(0, 9) < 4);
      BRANCH_EN     = ($urandom_range(0, 9) == 0);
      BRANCH_TARGET = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom_range(0, 255));
      if (BRANCH_EN) exp_pc = BRANCH_TARGET & ~32'h3;
      else if (INSTR_VALID && !STALL) exp_pc = exp_pc + 32'h4;
      p_hold  = INSTR_VALID && STALL && !BRANCH_EN;
      p_busy  = MEM_READ && MEM_BUSYWAIT;
      p_pc    = PC;
      p_instr = INSTRUCTION;
      p_addr  = MEM_ADDR;
    end
    STALL = 1'b0; BRANCH_EN = 1'b0;
    rand_wait = 1'b0;
    checks++; if (delivered < 50) $display("FAIL rnd_progress: got %0d deliveries want >=50", delivered);
    else passes++;
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; BRANCH_EN = 1'b0; BRANCH_TARGET = 32'h0;
    step();
    test_reset();
    test_zero_wait();
    test_busywait();
    test_stall();
    test_branch_deliver();
    test_branch_busy();
    test_reset_mid_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit: the producer side of the CPU's PC/INSTRUCTION interface.
- Holds the program counter and reads 32-bit instruction words from a word-organised instruction memory over a read/busywait handshake.
- Presents each word to the CPU core as PC plus INSTRUCTION with a valid flag, and honours core stall and branch-redirect requests.

Parameters:
- PC_WIDTH, 32, width of PC, MEM_ADDR and BRANCH_TARGET.
- RESET_PC, 0, PC value loaded on reset. Must be a multiple of 4.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  core is not ready to accept the current instruction.
- BRANCH_EN  in  1  redirect request from the core.
- BRANCH_TARGET  in  PC_WIDTH  redirect address. Bits [1:0] are ignored and treated as 0.
- PC  out  PC_WIDTH  address of the instruction on INSTRUCTION.
- INSTRUCTION  out  32  fetched instruction word.
- INSTR_VALID  out  1  INSTRUCTION/PC are valid for the core.
- MEM_READ  out  1  instruction memory read request.
- MEM_ADDR  out  PC_WIDTH  byte address of the read. Always 4-aligned.
- MEM_READDATA  in  32  read data, valid when MEM_BUSYWAIT=0 while MEM_READ=1.
- MEM_BUSYWAIT  in  1  memory not ready. The memory holds it high in every cycle of a read until data is valid.

Behaviour:
- Reset, applied on any edge with RESET=1, in any state, including mid-read:
  - PC=RESET_PC, INSTRUCTION=32'h0, INSTR_VALID=0, MEM_READ=0, MEM_ADDR=RESET_PC.
  - Pending-redirect flag cleared, state=FETCH.
  - An in-flight memory read is abandoned. Its data is never latched.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State FETCH:
  - MEM_READ=1, MEM_ADDR=PC, INSTR_VALID=0.
  - Edge with MEM_BUSYWAIT=1: hold.
  - Edge with MEM_BUSYWAIT=0 and no pending redirect:
    - INSTRUCTION<=MEM_READDATA, INSTR_VALID<=1, MEM_READ<=0.
    - Go to DELIVER.
  - Edge with MEM_BUSYWAIT=0 and a pending redirect:
    - Data is discarded. PC<=saved target, MEM_ADDR<=saved target.
    - Flag cleared. Stay in FETCH with MEM_READ held at 1.
  - BRANCH_EN=1 on any edge in FETCH: the target is saved and the flag set.
    - A later BRANCH_EN before data returns overwrites the saved target (last wins).
    - If BRANCH_EN=1 on the same edge that data returns, the data is discarded and PC<=BRANCH_TARGET directly.
- State DELIVER:
  - INSTR_VALID=1. INSTRUCTION and PC are stable.
  - BRANCH_EN=1 has priority over STALL. The current instruction is dropped:
    - PC<=BRANCH_TARGET, INSTR_VALID<=0.
    - Go to FETCH.
  - Else STALL=1: hold all outputs.
  - Else (accepted):
    - PC<=PC+4 modulo 2^PC_WIDTH. Wrap from all-ones-minus-3 to 0 is legal.
    - INSTR_VALID<=0. Go to FETCH.
- Latency and throughput:
  - A zero-wait memory (MEM_BUSYWAIT never asserted) gives the first INSTR_VALID 2 edges after RESET deasserts.
  - Unstalled throughput is 1 instruction per 2 cycles.
  - Each busywait cycle adds 1 cycle.
- STALL in FETCH has no effect: the fetch proceeds and the result waits in DELIVER.
- MEM_ADDR changes only when MEM_READ=0 or on a redirect edge. A request that has been raised is never dropped except by reset.

Test Plan:
- Reset then zero-wait memory returning word = 32'h0000_0B00 | addr:
  - INSTR_VALID pulses every 2nd cycle.
  - PC sequence 0,4,8,12.
  - INSTRUCTION matches the address at each valid.
- Memory with 3 busywait cycles per read:
  - MEM_READ stays high 4 cycles per fetch.
  - INSTR_VALID rises on the edge after busywait falls.
  - Consecutive valids are 5 cycles apart.
- STALL=1 for 4 cycles during DELIVER at PC=8:
  - PC=8 and INSTRUCTION are held for 4 cycles.
  - No memory read is issued.
  - After STALL drops, the next fetch uses MEM_ADDR=12.
- BRANCH_EN=1 with target 32'h40 in DELIVER while STALL=1:
  - Instruction dropped.
  - Next MEM_ADDR=0x40 and the next valid PC=0x40.
  - Target 32'h43 also yields 0x40.
- Branches during a busywait fetch at PC=0x10:
  - BRANCH_EN with target 0x80, then with target 0x90, while busywait is high.
  - Returned data is discarded, with no valid pulse.
  - Re-fetch at 0x90.
- Mid-read reset and PC wrap:
  - RESET asserted mid-busywait: next cycle MEM_READ=0, INSTR_VALID=0, PC=RESET_PC.
  - Separately, branch to 32'hFFFF_FFFC and accept: next PC=0.
